// File: rtl/serializer_pkg.sv
// Shared types and helpers for the stream serializer: shifter state encoding
// and the decode from the raw length field to a bit count.
package serializer_pkg;

    typedef enum logic {
        IDLE_S = 1'b0,
        WORK_S = 1'b1
    } ser_state_e;

    // A zero length field stands for a full word; oversized fields saturate.
    function automatic int unsigned decode_len(input int unsigned mod,
                                               input int unsigned width);
        if (mod == 0 || mod > width)
            return width;
        return mod;
    endfunction

endpackage

// File: rtl/ser_shifter.sv
// Serializing datapath: loads a word with its bit count and order, then
// presents one bit per shift, flagging the final bit via a down-counter.
module ser_shifter
    import serializer_pkg::*;
#(
    parameter int unsigned DATA_BUS_WIDTH = 16,
    parameter int unsigned DATA_MOD_WIDTH = $clog2(DATA_BUS_WIDTH)
) (
    input  logic                      clk_i,
    input  logic                      srst_i,
    input  logic                      load_i,
    input  logic                      shift_i,
    input  logic [DATA_BUS_WIDTH-1:0] load_data_i,
    input  logic [DATA_MOD_WIDTH-1:0] load_mod_i,
    input  logic                      load_msb_i,
    output logic                      bit_o,
    output logic                      last_o
);

    localparam int unsigned CNT_W = DATA_MOD_WIDTH + 1;

    logic [DATA_BUS_WIDTH-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic                      msb_q, msb_d;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        msb_d   = msb_q;
        if (load_i) begin
            shreg_d = load_data_i;
            cnt_d   = CNT_W'(decode_len(32'(load_mod_i), DATA_BUS_WIDTH) - 1);
            msb_d   = load_msb_i;
        end else if (shift_i && cnt_q != '0) begin
            shreg_d = msb_q ? {shreg_q[DATA_BUS_WIDTH-2:0], 1'b0}
                            : {1'b0, shreg_q[DATA_BUS_WIDTH-1:1]};
            cnt_d   = cnt_q - 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments; data registers are
    // reset too so a word cut off by reset leaves nothing behind.
    always_ff @(posedge clk_i or posedge srst_i) begin
        if (srst_i) begin
            shreg_q <= '0;
            cnt_q   <= '0;
            msb_q   <= 1'b0;
        end else begin
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            msb_q   <= msb_d;
        end
    end

    assign bit_o  = msb_q ? shreg_q[DATA_BUS_WIDTH-1] : shreg_q[0];
    assign last_o = (cnt_q == '0);

endmodule

// File: rtl/stream_serializer.sv
// Parallel-to-serial converter with one pending slot behind the active
// shifter, so back-to-back words stream without idle cycles.
module stream_serializer
    import serializer_pkg::*;
#(
    parameter int unsigned DATA_BUS_WIDTH = 16,
    parameter int unsigned DATA_MOD_WIDTH = $clog2(DATA_BUS_WIDTH),
    parameter int unsigned MIN_LEN        = 3
) (
    input  logic                      clk_i,
    input  logic                      srst_i,
    input  logic [DATA_BUS_WIDTH-1:0] data_i,
    input  logic [DATA_MOD_WIDTH-1:0] data_mod_i,
    input  logic                      msb_first_i,
    input  logic                      data_val_i,
    output logic                      data_rdy_o,
    output logic                      ser_data_o,
    output logic                      ser_data_val_o,
    output logic                      ser_last_o,
    output logic                      busy_o
);

    ser_state_e                state_q, state_d;
    logic                      pend_valid_q, pend_valid_d;
    logic [DATA_BUS_WIDTH-1:0] pend_data_q, pend_data_d;
    logic [DATA_MOD_WIDTH-1:0] pend_mod_q, pend_mod_d;
    logic                      pend_msb_q, pend_msb_d;

    logic                      load;
    logic [DATA_BUS_WIDTH-1:0] load_data;
    logic [DATA_MOD_WIDTH-1:0] load_mod;
    logic                      load_msb;
    logic                      sh_bit, sh_last;
    logic                      accept_keep, last_bit, shifter_free;

    // Short nonzero lengths are consumed by the handshake but never stored.
    assign accept_keep  = data_val_i && data_rdy_o &&
                          !(data_mod_i != '0 && 32'(data_mod_i) < MIN_LEN);
    assign last_bit     = (state_q == WORK_S) && sh_last;
    assign shifter_free = (state_q == IDLE_S) || last_bit;

    always_comb begin
        state_d      = state_q;
        pend_valid_d = pend_valid_q;
        pend_data_d  = pend_data_q;
        pend_mod_d   = pend_mod_q;
        pend_msb_d   = pend_msb_q;
        load         = 1'b0;
        load_data    = data_i;
        load_mod     = data_mod_i;
        load_msb     = msb_first_i;
        // An accept implies the pending slot is empty, so the branches are exclusive.
        if (accept_keep && shifter_free) begin
            load    = 1'b1;
            state_d = WORK_S;
        end else if (accept_keep) begin
            pend_valid_d = 1'b1;
            pend_data_d  = data_i;
            pend_mod_d   = data_mod_i;
            pend_msb_d   = msb_first_i;
        end else if (last_bit && pend_valid_q) begin
            load         = 1'b1;
            load_data    = pend_data_q;
            load_mod     = pend_mod_q;
            load_msb     = pend_msb_q;
            pend_valid_d = 1'b0;
        end else if (last_bit) begin
            state_d = IDLE_S;
        end
    end

    always_ff @(posedge clk_i or posedge srst_i) begin
        if (srst_i) begin
            state_q      <= IDLE_S;
            pend_valid_q <= 1'b0;
            pend_data_q  <= '0;
            pend_mod_q   <= '0;
            pend_msb_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            pend_valid_q <= pend_valid_d;
            pend_data_q  <= pend_data_d;
            pend_mod_q   <= pend_mod_d;
            pend_msb_q   <= pend_msb_d;
        end
    end

    ser_shifter #(
        .DATA_BUS_WIDTH(DATA_BUS_WIDTH),
        .DATA_MOD_WIDTH(DATA_MOD_WIDTH)
    ) u_shifter (
        .clk_i      (clk_i),
        .srst_i     (srst_i),
        .load_i     (load),
        .shift_i    (state_q == WORK_S),
        .load_data_i(load_data),
        .load_mod_i (load_mod),
        .load_msb_i (load_msb),
        .bit_o      (sh_bit),
        .last_o     (sh_last)
    );

    assign data_rdy_o     = !pend_valid_q;
    assign ser_data_val_o = (state_q == WORK_S);
    assign ser_data_o     = ser_data_val_o && sh_bit;
    assign ser_last_o     = last_bit;
    assign busy_o         = (state_q == WORK_S) || pend_valid_q;

endmodule

// File: tb/tb_stream_serializer.sv
// Directed bench for stream_serializer (W=16, MIN_LEN=3) with hand-computed
// expected bit sequences, handshake and reset behaviour.
module tb_stream_serializer;

    logic        clk_i = 1'b0;
    logic        srst_i;
    logic [15:0] data_i;
    logic [3:0]  data_mod_i;
    logic        msb_first_i;
    logic        data_val_i;
    logic        data_rdy_o;
    logic        ser_data_o;
    logic        ser_data_val_o;
    logic        ser_last_o;
    logic        busy_o;

    int vectors     = 0;
    int miscompares = 0;

    stream_serializer #(
        .DATA_BUS_WIDTH(16),
        .DATA_MOD_WIDTH(4),
        .MIN_LEN       (3)
    ) dut (
        .clk_i         (clk_i),
        .srst_i        (srst_i),
        .data_i        (data_i),
        .data_mod_i    (data_mod_i),
        .msb_first_i   (msb_first_i),
        .data_val_i    (data_val_i),
        .data_rdy_o    (data_rdy_o),
        .ser_data_o    (ser_data_o),
        .ser_data_val_o(ser_data_val_o),
        .ser_last_o    (ser_last_o),
        .busy_o        (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1ns after the rising edge.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, " rdy"},  32'(data_rdy_o),     32'd1);
        check({tag, " val"},  32'(ser_data_val_o), 32'd0);
        check({tag, " data"}, 32'(ser_data_o),     32'd0);
        check({tag, " last"}, 32'(ser_last_o),     32'd0);
        check({tag, " busy"}, 32'(busy_o),         32'd0);
    endtask

    initial begin
        logic [15:0] full_bits;
        logic [4:0]  lsb_bits;
        logic [11:0] b2b_bits;
        logic [11:0] b2b_rdy;
        logic        seen_val;

        full_bits = 16'b1010_0101_1100_0011;
        lsb_bits  = 5'b10011;
        b2b_bits  = 12'b1111_0000_1111;
        b2b_rdy   = 12'b1111_0001_0001;

        srst_i      = 1'b1;
        data_i      = '0;
        data_mod_i  = '0;
        msb_first_i = 1'b0;
        data_val_i  = 1'b0;

        // Reset values are visible before the first clock edge.
        #1;
        check_idle("reset_async");
        step();
        step();
        srst_i = 1'b0;
        step();
        check_idle("after_reset");

        // Full 16-bit word, MSB first.
        data_i = 16'hA5C3; data_mod_i = 4'd0; msb_first_i = 1'b1; data_val_i = 1'b1;
        step();
        data_val_i = 1'b0;
        for (int i = 0; i < 16; i++) begin
            check($sformatf("full val%0d", i),  32'(ser_data_val_o), 32'd1);
            check($sformatf("full bit%0d", i),  32'(ser_data_o),     32'(full_bits[15-i]));
            check($sformatf("full last%0d", i), 32'(ser_last_o),     32'(i == 15));
            step();
        end
        check_idle("full_done");

        // Short word, LSB first, length 5.
        data_i = 16'h0013; data_mod_i = 4'd5; msb_first_i = 1'b0; data_val_i = 1'b1;
        step();
        data_val_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("lsb val%0d", i),  32'(ser_data_val_o), 32'd1);
            check($sformatf("lsb bit%0d", i),  32'(ser_data_o),     32'(lsb_bits[i]));
            check($sformatf("lsb last%0d", i), 32'(ser_last_o),     32'(i == 4));
            step();
        end
        check_idle("lsb_done");

        // Length 2 is below the minimum: consumed, never sent.
        data_i = 16'hFFFF; data_mod_i = 4'd2; msb_first_i = 1'b1; data_val_i = 1'b1;
        check("drop rdy_before", 32'(data_rdy_o), 32'd1);
        step();
        data_val_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check_idle($sformatf("drop c%0d", i));
            step();
        end

        // Three back-to-back 4-bit words with data_val_i held high.
        data_i = 16'hF000; data_mod_i = 4'd4; msb_first_i = 1'b1; data_val_i = 1'b1;
        step();
        for (int i = 0; i < 12; i++) begin
            check($sformatf("b2b val%0d", i),  32'(ser_data_val_o), 32'd1);
            check($sformatf("b2b bit%0d", i),  32'(ser_data_o),     32'(b2b_bits[11-i]));
            check($sformatf("b2b last%0d", i), 32'(ser_last_o),     32'(i % 4 == 3));
            check($sformatf("b2b rdy%0d", i),  32'(data_rdy_o),     32'(b2b_rdy[i]));
            check($sformatf("b2b busy%0d", i), 32'(busy_o),         32'd1);
            if (i == 0) data_i = 16'h0000;
            if (i == 1) data_i = 16'hF000;
            if (i == 5) data_val_i = 1'b0;
            step();
        end
        check_idle("b2b_done");

        // Reset asserted during the 7th bit with a second word pending.
        data_i = 16'hFFFF; data_mod_i = 4'd0; msb_first_i = 1'b1; data_val_i = 1'b1;
        step();
        data_i = 16'h0F0F;
        step();
        data_val_i = 1'b0;
        check("mid pend_full", 32'(data_rdy_o), 32'd0);
        for (int i = 0; i < 5; i++) step();
        check("mid bit7_val", 32'(ser_data_val_o), 32'd1);
        check("mid bit7_data", 32'(ser_data_o), 32'd1);
        #2;
        srst_i = 1'b1;
        #1;
        check_idle("mid_reset_async");
        step();
        srst_i = 1'b0;
        seen_val = 1'b0;
        for (int i = 0; i < 24; i++) begin
            step();
            seen_val = seen_val | ser_data_val_o | busy_o;
        end
        check("mid no_residual", 32'(seen_val), 32'd0);

        // Next word after reset: 16'h0006, length 3, LSB first -> 0,1,1.
        data_i = 16'h0006; data_mod_i = 4'd3; msb_first_i = 1'b0; data_val_i = 1'b1;
        step();
        data_val_i = 1'b0;
        check("post bit0", 32'({ser_data_val_o, ser_data_o, ser_last_o}), 32'b100);
        step();
        check("post bit1", 32'({ser_data_val_o, ser_data_o, ser_last_o}), 32'b110);
        step();
        check("post bit2", 32'({ser_data_val_o, ser_data_o, ser_last_o}), 32'b111);
        step();
        check_idle("post_done");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
